// File: rtl/imm_gen_pkg.sv
// Shared encodings and helpers for the RV32I immediate generator.
// Imported by the combinational decoder and the registered wrapper.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_U   = 3'b010,
    IMM_SH  = 3'b011,
    IMM_Z   = 3'b100,
    IMM_B   = 3'b101,
    IMM_J   = 3'b110,
    IMM_RSV = 3'b111
  } imm_src_e;

  localparam int XLEN   = 32;
  localparam int IBITS  = 25;

  function automatic logic [XLEN-1:0] sext12(
    input logic [11:0] v
  );
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext13(
    input logic [12:0] v
  );
    return {{19{v[12]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext21(
    input logic [20:0] v
  );
    return {{11{v[20]}}, v};
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction for all RV32I formats.
// Instr[k] carries instruction bit k+7.
module imm_decode
  import imm_gen_pkg::*;
(
  input  logic [24:0] Instr,
  input  logic [2:0]  ImmSrc,
  output logic [31:0] ImmExt,
  output logic        IllegalSrc
);

  logic [11:0] w_i;
  logic [11:0] w_s;
  logic [12:0] w_b;
  logic [20:0] w_j;

  assign w_i = Instr[24:13];
  assign w_s = {Instr[24:18], Instr[4:0]};
  assign w_b = {Instr[24], Instr[0],
                Instr[23:18], Instr[4:1], 1'b0};
  assign w_j = {Instr[24], Instr[12:5],
                Instr[13], Instr[23:14], 1'b0};

  always_comb begin
    ImmExt     = 32'h0000_0000;
    IllegalSrc = 1'b0;
    case (ImmSrc)
      IMM_I:   ImmExt = sext12(w_i);
      IMM_S:   ImmExt = sext12(w_s);
      IMM_U:   ImmExt = {Instr[24:5], 12'h000};
      IMM_SH:  ImmExt = {27'd0, Instr[17:13]};
      IMM_Z:   ImmExt = {27'd0, Instr[12:8]};
      IMM_B:   ImmExt = sext13(w_b);
      IMM_J:   ImmExt = sext21(w_j);
      IMM_RSV: IllegalSrc = 1'b1;
      default: begin
        ImmExt     = 32'h0000_0000;
        IllegalSrc = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen.sv
// Immediate generator: combinational decode plus a one-cycle
// enabled output register with synchronous active-low reset.
module imm_gen
  import imm_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [24:0] Instr,
  input  logic [2:0]  ImmSrc,
  input  logic        En,
  output logic [31:0] ImmExt,
  output logic        IllegalSrc,
  output logic [31:0] ImmExtQ,
  output logic        ValidQ
);

  logic [31:0] w_imm;
  logic        w_ill;
  logic [31:0] r_imm_q;
  logic        r_valid_q;

  imm_decode u_dec (
    .Instr      (Instr),
    .ImmSrc     (ImmSrc),
    .ImmExt     (w_imm),
    .IllegalSrc (w_ill)
  );

  // Reset wins over En so a mid-stream reset never half-loads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_imm_q   <= 32'h0000_0000;
      r_valid_q <= 1'b0;
    end else if (En) begin
      r_imm_q   <= w_imm;
      r_valid_q <= ~w_ill;
    end
  end

  assign ImmExt     = w_imm;
  assign IllegalSrc = w_ill;
  assign ImmExtQ    = r_imm_q;
  assign ValidQ     = r_valid_q;

endmodule

// File: tb/tb_imm_gen.sv
// Scoreboard bench for imm_gen: directed vectors, queued expectations,
// negedge monitor comparing combinational and registered outputs.
module tb_imm_gen;
  import imm_gen_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [24:0] Instr;
  logic [2:0]  ImmSrc;
  logic        En;
  logic [31:0] ImmExt;
  logic        IllegalSrc;
  logic [31:0] ImmExtQ;
  logic        ValidQ;

  int checks = 0;
  int errors = 0;

  logic [32:0] cq[$];
  logic [32:0] rq[$];

  imm_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Instr      (Instr),
    .ImmSrc     (ImmSrc),
    .En         (En),
    .ImmExt     (ImmExt),
    .IllegalSrc (IllegalSrc),
    .ImmExtQ    (ImmExtQ),
    .ValidQ     (ValidQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [32:0] e;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      checks++;
      if (ImmExt !== e[32:1]) begin
        errors++;
        $display("FAIL ImmExt got %h exp %h src %b instr %h",
                 ImmExt, e[32:1], ImmSrc, Instr);
      end
      checks++;
      if (IllegalSrc !== e[0]) begin
        errors++;
        $display("FAIL IllegalSrc got %b exp %b src %b",
                 IllegalSrc, e[0], ImmSrc);
      end
    end
    if (rq.size() > 0) begin
      e = rq.pop_front();
      checks++;
      if (ImmExtQ !== e[32:1]) begin
        errors++;
        $display("FAIL ImmExtQ got %h exp %h", ImmExtQ, e[32:1]);
      end
      checks++;
      if (ValidQ !== e[0]) begin
        errors++;
        $display("FAIL ValidQ got %b exp %b", ValidQ, e[0]);
      end
    end
  end

  // Drive one vector after a posedge, then queue the register
  // state expected once the following edge has captured it.
  task automatic step(
    input logic        rst,
    input logic        en,
    input logic [24:0] ins,
    input logic [2:0]  src,
    input logic [31:0] x_imm,
    input logic        x_ill,
    input logic [31:0] x_q,
    input logic        x_v
  );
    #1;
    rst_n  = rst;
    En     = en;
    Instr  = ins;
    ImmSrc = src;
    cq.push_back({x_imm, x_ill});
    @(posedge clk);
    rq.push_back({x_q, x_v});
  endtask

  localparam logic [24:0] V_I = 25'h1000000;
  localparam logic [24:0] V_S = 25'b0010101_0000000000000_10101;
  localparam logic [24:0] V_B = 25'b1111111_0000000000000_10111;
  localparam logic [24:0] V_U = 25'b0011001100110011001100110;
  localparam logic [24:0] V_J = 25'b1111001100111111111100000;

  initial begin
    rst_n  = 1'b0;
    En     = 1'b0;
    Instr  = '0;
    ImmSrc = IMM_I;
    @(posedge clk);
    step(0, 1, V_I, IMM_I, 32'hFFFF_F800, 0, 32'h0, 0);
    step(1, 1, V_I, IMM_I, 32'hFFFF_F800, 0, 32'hFFFF_F800, 1);
    step(1, 0, V_U, IMM_U, 32'h3333_3000, 0, 32'hFFFF_F800, 1);
    step(1, 1, V_S, IMM_S, 32'h0000_02B5, 0, 32'h0000_02B5, 1);
    step(1, 1, V_B, IMM_B, 32'hFFFF_FFF6, 0, 32'hFFFF_FFF6, 1);
    step(1, 1, V_J, IMM_J, 32'hFFFF_FF32, 0, 32'hFFFF_FF32, 1);
    step(1, 1, 25'h1FFFFFF, IMM_RSV, 32'h0, 1, 32'h0, 0);
    step(1, 1, 25'h1FEDFFF, IMM_SH, 32'h16, 0, 32'h16, 1);
    step(1, 1, 25'h1FFE9FF, IMM_Z, 32'h9, 0, 32'h9, 1);
    step(1, 1, 25'h0FFFFFF, IMM_I, 32'h7FF, 0, 32'h7FF, 1);
    step(0, 1, V_J, IMM_J, 32'hFFFF_FF32, 0, 32'h0, 0);
    step(1, 0, V_U, IMM_U, 32'h3333_3000, 0, 32'h0, 0);
    step(1, 1, 25'h0, IMM_RSV, 32'h0, 1, 32'h0, 0);
    step(1, 1, V_S, IMM_S, 32'h0000_02B5, 0, 32'h0000_02B5, 1);
    #1;
    En = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cq.size() == 0 && rq.size() == 0) break;
      @(posedge clk);
    end
    checks++;
    if (cq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d/%0d entries",
               cq.size(), rq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen.md
IMM_GEN -- requirements
Module: imm_gen

Interface
REQ-001 Parameters: none; all widths fixed for RV32I.
REQ-002 clk  input  1  single clock, rising edge; the only clock in the block.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 Instr  input  25  instruction bits [31:7]; Instr[k] = instruction bit k+7.
REQ-005 ImmSrc  input  3  immediate format select.
REQ-006 En  input  1  capture enable for the registered stage.
REQ-007 ImmExt  output  32  combinational sign/zero-extended immediate.
REQ-008 IllegalSrc  output  1  combinational; 1 when ImmSrc is the reserved code.
REQ-009 ImmExtQ  output  32  registered copy of ImmExt.
REQ-010 ValidQ  output  1  registered flag; 1 when ImmExtQ holds a legal immediate.

Function
REQ-011 ImmExt and IllegalSrc SHALL be purely combinational from Instr and ImmSrc, with zero-cycle latency and no dependence on clk, rst_n or En.
REQ-012 ImmSrc=000, I-type: ImmExt = sign-extend(Instr[24:13]), 12 bits.
REQ-013 ImmSrc=001, S-type: ImmExt = sign-extend({Instr[24:18], Instr[4:0]}), 12 bits.
REQ-014 ImmSrc=101, B-type: ImmExt = sign-extend({Instr[24], Instr[0], Instr[23:18], Instr[4:1], 1'b0}), 13 bits.
REQ-015 ImmSrc=010, U-type: ImmExt = {Instr[24:5], 12'h000}.
REQ-016 ImmSrc=110, J-type: ImmExt = sign-extend({Instr[24], Instr[12:5], Instr[13], Instr[23:14], 1'b0}), 21 bits.
REQ-017 ImmSrc=011, shift amount: ImmExt = zero-extend(Instr[17:13]).
REQ-018 ImmSrc=100, CSR zimm: ImmExt = zero-extend(Instr[12:8]).
REQ-019 ImmSrc=111 is reserved: ImmExt = 32'h0000_0000 and IllegalSrc = 1.
REQ-020 IllegalSrc SHALL be 0 for every other ImmSrc code.
REQ-021 Sign extension SHALL always use Instr[24] as the sign bit for I, S, B and J formats.
REQ-022 Instr bits not used by the selected format SHALL have no effect on ImmExt.
REQ-023 On each rising clk edge with rst_n=1 and En=1, the block SHALL load ImmExtQ <= ImmExt and ValidQ <= ~IllegalSrc.
REQ-024 On each rising clk edge with rst_n=1 and En=0, ImmExtQ and ValidQ SHALL hold their values.
REQ-025 Registered latency SHALL be one cycle from input change to ImmExtQ update.

Reset
REQ-026 On a rising clk edge with rst_n=0, the block SHALL set ImmExtQ=32'h0 and ValidQ=0; reset overrides En.
REQ-027 ImmExt and IllegalSrc SHALL remain valid combinational functions of the inputs during reset.
REQ-028 When reset is asserted mid-stream, the registers SHALL clear on that edge with no partial update.

Structure
REQ-029 A shared package SHALL define the ImmSrc encodings as named 3-bit constants/enum (IMM_I=000, IMM_S=001, IMM_U=010, IMM_SH=011, IMM_Z=100, IMM_B=101, IMM_J=110, IMM_RSV=111).
REQ-030 The combinational decoder SHALL be a natural sub-module, imm_decode (Instr, ImmSrc -> ImmExt, IllegalSrc).
REQ-031 imm_gen SHALL wrap imm_decode and add the output register stage.
REQ-032 The design SHALL contain no latches, and every case SHALL have a default assignment.

Verification
REQ-033 I: Instr=25'h1000000, ImmSrc=000 -> ImmExt=32'hFFFF_F800 (-2048); IllegalSrc=0.
REQ-034 S: Instr=25'b0010101_0000000000000_10101, ImmSrc=001 -> ImmExt=32'h0000_02B5 (693).
REQ-035 B: Instr=25'b1111111_0000000000000_10111, ImmSrc=101 -> ImmExt=32'hFFFF_FFF6 (-10).
REQ-036 U then J:
- U: Instr=25'b0011001100110011001100110, ImmSrc=010 -> ImmExt=32'h3333_3000.
- J: Instr=25'b1111001100111111111100000, ImmSrc=110 -> ImmExt=32'hFFFF_FF32 (-206).
REQ-037 Register stage:
- rst_n=0 for one edge -> ImmExtQ=0, ValidQ=0.
- Then En=1 with the I vector -> next edge ImmExtQ=32'hFFFF_F800, ValidQ=1.
- Then En=0 with the U vector -> ImmExtQ holds 32'hFFFF_F800.
REQ-038 Reserved code: ImmSrc=111 with Instr=25'h1FFFFFF -> ImmExt=0, IllegalSrc=1; after an En=1 edge, ValidQ=0.
